// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo core.
// Holds the operand/tag widths, the instruction field positions,
// the reservation-station entry state and the entry payload struct.
package tomasulo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RD_W   = 4;

  // Tag 0 means "value present, no producer".
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  // Field positions inside a 16-bit instruction word.
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 8;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_t;

  typedef struct packed {
    rs_state_t         state;
    logic [OP_W-1:0]   op;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: holds an instruction, snoops the CDB for
// missing operands and frees itself when its own tag completes.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   disp_we              write the dispatch payload into this (FREE) entry
//   disp_op..disp_qk     dispatch payload
//   cdb_valid/tag/data   common data bus
//   issue                this entry was accepted by the FU this cycle
//   ent                  registered entry contents
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter logic [TAG_W-1:0] MY_TAG = 3'd1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_we,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [RD_W-1:0]   disp_rd,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              issue,
  output rs_entry_t         ent
);

  rs_entry_t ent_q, ent_d;
  logic      cdb_hit;

  // Next-entry logic: dispatch with same-cycle bypass, snoop, issue, completion.
  always_comb begin
    ent_d   = ent_q;
    cdb_hit = cdb_valid && (cdb_tag != TAG_NONE);
    case (ent_q.state)
      FREE: begin
        if (disp_we) begin
          ent_d.op = disp_op;
          ent_d.rd = disp_rd;
          ent_d.vj = disp_vj;
          ent_d.vk = disp_vk;
          ent_d.qj = disp_qj;
          ent_d.qk = disp_qk;
          if (cdb_hit && (cdb_tag == disp_qj)) begin
            ent_d.vj = cdb_data;
            ent_d.qj = TAG_NONE;
          end
          if (cdb_hit && (cdb_tag == disp_qk)) begin
            ent_d.vk = cdb_data;
            ent_d.qk = TAG_NONE;
          end
          ent_d.state = ((ent_d.qj == TAG_NONE) && (ent_d.qk == TAG_NONE)) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (cdb_hit && (cdb_tag == ent_q.qj)) begin
          ent_d.vj = cdb_data;
          ent_d.qj = TAG_NONE;
        end
        if (cdb_hit && (cdb_tag == ent_q.qk)) begin
          ent_d.vk = cdb_data;
          ent_d.qk = TAG_NONE;
        end
        if ((ent_d.qj == TAG_NONE) && (ent_d.qk == TAG_NONE)) begin
          ent_d.state = READY;
        end
      end
      READY: begin
        if (issue) ent_d.state = EXEC;
      end
      EXEC: begin
        // Own tag on the CDB means the FU result for this entry is out.
        if (cdb_valid && (cdb_tag == MY_TAG)) ent_d.state = FREE;
      end
      default: ent_d.state = FREE;
    endcase
  end

  // Entry register.
  always_ff @(posedge clock) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign ent = ent_q;

endmodule

// File: rtl/reserve_station.sv
// Reservation station feeding one functional unit.
// Accepts one instruction per cycle into the lowest free entry, snoops the
// CDB for missing operands and offers the lowest ready entry to the FU.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   disp_valid/ready/tag, disp_*  dispatch interface
//   cdb_valid/tag/data            common data bus
//   fu_valid/ready, fu_*          issue interface (fu_* combinational from state)
module reserve_station #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned TAG_W    = 3,
  parameter int unsigned TAG_BASE = 1,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_op,
  input  logic [3:0]        disp_rd,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [TAG_W-1:0]  disp_qk,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_valid,
  input  logic              fu_ready,
  output logic [3:0]        fu_op,
  output logic [3:0]        fu_rd,
  output logic [DATA_W-1:0] fu_vj,
  output logic [DATA_W-1:0] fu_vk,
  output logic [TAG_W-1:0]  fu_tag
);

  import tomasulo_pkg::*;

  rs_entry_t          ents [DEPTH];
  logic [DEPTH-1:0]   free_oh, rdy_oh, disp_we, issue;
  logic               any_free, any_rdy;
  logic [TAG_W-1:0]   free_tag;

  // Lowest-index FREE and READY entries, as one-hot selects.
  always_comb begin
    free_oh  = '0;
    rdy_oh   = '0;
    any_free = 1'b0;
    any_rdy  = 1'b0;
    free_tag = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!any_free && (ents[i].state == FREE)) begin
        any_free   = 1'b1;
        free_oh[i] = 1'b1;
        free_tag   = TAG_W'(TAG_BASE + i);
      end
      if (!any_rdy && (ents[i].state == READY)) begin
        any_rdy   = 1'b1;
        rdy_oh[i] = 1'b1;
      end
    end
  end

  // Handshakes; both are blocked while reset is high.
  assign disp_ready = any_free & ~reset;
  assign disp_tag   = disp_ready ? free_tag : '0;
  assign fu_valid   = any_rdy & ~reset;
  assign disp_we    = (disp_valid && disp_ready) ? free_oh : '0;
  assign issue      = (fu_valid && fu_ready) ? rdy_oh : '0;

  // Issue payload mux; all zero when nothing is offered.
  always_comb begin
    fu_op  = '0;
    fu_rd  = '0;
    fu_vj  = '0;
    fu_vk  = '0;
    fu_tag = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fu_valid && rdy_oh[i]) begin
        fu_op  = ents[i].op;
        fu_rd  = ents[i].rd;
        fu_vj  = ents[i].vj;
        fu_vk  = ents[i].vk;
        fu_tag = TAG_W'(TAG_BASE + i);
      end
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ent
    rs_entry #(
      .MY_TAG (TAG_W'(TAG_BASE + g))
    ) u_ent (
      .clock     (clock),
      .reset     (reset),
      .disp_we   (disp_we[g]),
      .disp_op   (disp_op),
      .disp_rd   (disp_rd),
      .disp_vj   (disp_vj),
      .disp_vk   (disp_vk),
      .disp_qj   (disp_qj),
      .disp_qk   (disp_qk),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .issue     (issue[g]),
      .ent       (ents[g])
    );
  end

endmodule

// File: tb/tb_reserve_station.sv
// Self-checking bench for reserve_station: directed vector table, two
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_reserve_station;

  localparam int DEPTH    = 3;
  localparam int TAG_BASE = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_op, disp_rd;
  logic [15:0] disp_vj, disp_vk;
  logic [2:0]  disp_qj, disp_qk, disp_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        fu_valid, fu_ready;
  logic [3:0]  fu_op, fu_rd;
  logic [15:0] fu_vj, fu_vk;
  logic [2:0]  fu_tag;

  always #5 clock = ~clock;

  reserve_station #(.DEPTH(3), .TAG_W(3), .TAG_BASE(1), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_rd(disp_rd), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_op(fu_op), .fu_rd(fu_rd), .fu_vj(fu_vj), .fu_vk(fu_vk), .fu_tag(fu_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic dv, input logic [3:0] op, input logic [3:0] rd,
                        input logic [15:0] vj, input logic [15:0] vk, input logic [2:0] qj,
                        input logic [2:0] qk, input logic cv, input logic [2:0] ct,
                        input logic [15:0] cd, input logic fr);
    reset = rst; disp_valid = dv; disp_op = op; disp_rd = rd; disp_vj = vj; disp_vk = vk;
    disp_qj = qj; disp_qk = qk; cdb_valid = cv; cdb_tag = ct; cdb_data = cd; fu_ready = fr;
  endtask

  task automatic check_out(input string nm, input logic dr, input logic [2:0] dt, input logic fv,
                           input logic [2:0] ft, input logic [3:0] op, input logic [3:0] rd,
                           input logic [15:0] vj, input logic [15:0] vk);
    chk({nm, ".disp_ready"}, disp_ready, dr);
    chk({nm, ".disp_tag"},   disp_tag,   dt);
    chk({nm, ".fu_valid"},   fu_valid,   fv);
    chk({nm, ".fu_tag"},     fu_tag,     ft);
    chk({nm, ".fu_op"},      fu_op,      op);
    chk({nm, ".fu_rd"},      fu_rd,      rd);
    chk({nm, ".fu_vj"},      fu_vj,      vj);
    chk({nm, ".fu_vk"},      fu_vk,      vk);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Directed vector: inputs for one cycle and the outputs expected before its edge.
  typedef struct {
    logic rst, dv; logic [3:0] op, rd; logic [15:0] vj, vk; logic [2:0] qj, qk;
    logic cv; logic [2:0] ct; logic [15:0] cd; logic fr;
    logic e_dr; logic [2:0] e_dt; logic e_fv; logic [2:0] e_ft;
    logic [3:0] e_op, e_rd; logic [15:0] e_vj, e_vk;
  } vec_t;

  function automatic vec_t mk(logic rst, logic dv, logic [3:0] op, logic [3:0] rd, logic [15:0] vj,
                              logic [15:0] vk, logic [2:0] qj, logic [2:0] qk, logic cv,
                              logic [2:0] ct, logic [15:0] cd, logic fr, logic edr, logic [2:0] edt,
                              logic efv, logic [2:0] eft, logic [3:0] eop, logic [3:0] erd,
                              logic [15:0] evj, logic [15:0] evk);
    vec_t v;
    v.rst = rst; v.dv = dv; v.op = op; v.rd = rd; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
    v.cv = cv; v.ct = ct; v.cd = cd; v.fr = fr;
    v.e_dr = edr; v.e_dt = edt; v.e_fv = efv; v.e_ft = eft; v.e_op = eop; v.e_rd = erd;
    v.e_vj = evj; v.e_vk = evk;
    return v;
  endfunction

  // Behavioural model: each slot is busy/issued plus operands.
  typedef struct {
    bit busy; bit issued;
    logic [3:0] op, rd; logic [15:0] vj, vk; logic [2:0] qj, qk;
  } ment_t;

  ment_t m [DEPTH];

  function automatic int first_free();
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy && !m[i].issued && m[i].qj == 0 && m[i].qk == 0) return i;
    return -1;
  endfunction

  task automatic model_check(input string nm);
    int ff, ri;
    ff = first_free();
    ri = first_ready();
    if (reset) check_out(nm, 0, 0, 0, 0, 0, 0, 0, 0);
    else if (ri < 0)
      check_out(nm, ff >= 0, (ff >= 0) ? 3'(TAG_BASE + ff) : 3'd0, 0, 0, 0, 0, 0, 0);
    else
      check_out(nm, ff >= 0, (ff >= 0) ? 3'(TAG_BASE + ff) : 3'd0, 1, 3'(TAG_BASE + ri),
                m[ri].op, m[ri].rd, m[ri].vj, m[ri].vk);
  endtask

  task automatic model_step();
    ment_t nm [DEPTH];
    int ff, ri;
    ff = first_free();
    ri = first_ready();
    nm = m;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) nm[i] = '{default: 0};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].busy && m[i].issued) begin
          if (cdb_valid && cdb_tag == 3'(TAG_BASE + i)) nm[i].busy = 0;
        end else if (m[i].busy && cdb_valid && cdb_tag != 0) begin
          if (m[i].qj == cdb_tag) begin nm[i].vj = cdb_data; nm[i].qj = 0; end
          if (m[i].qk == cdb_tag) begin nm[i].vk = cdb_data; nm[i].qk = 0; end
        end
      end
      if (ri >= 0 && fu_ready) nm[ri].issued = 1;
      if (disp_valid && ff >= 0) begin
        nm[ff].busy = 1; nm[ff].issued = 0;
        nm[ff].op = disp_op; nm[ff].rd = disp_rd;
        nm[ff].vj = disp_vj; nm[ff].vk = disp_vk;
        nm[ff].qj = disp_qj; nm[ff].qk = disp_qk;
        if (cdb_valid && cdb_tag != 0 && cdb_tag == disp_qj) begin nm[ff].vj = cdb_data; nm[ff].qj = 0; end
        if (cdb_valid && cdb_tag != 0 && cdb_tag == disp_qk) begin nm[ff].vk = cdb_data; nm[ff].qk = 0; end
      end
    end
    m = nm;
  endtask

  vec_t vt[$];

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset
    vt.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0,0));
    // Ready dispatch, issue, complete
    vt.push_back(mk(0,1,2,3,16'h10,16'h20,0,0, 0,0,0,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  1,2,1,1,2,3,16'h10,16'h20));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,1,16'h9999,0,  1,2,0,0,0,0,0,0));
    // Wait on tag 5, then snoop
    vt.push_back(mk(0,1,1,4,0,16'h7,5,0, 0,0,0,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,  1,2,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,  1,2,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,  1,2,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,5,16'h1234,0,  1,2,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  1,2,1,1,1,4,16'h1234,16'h7));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,  1,2,0,0,0,0,0,0));
    // Same-cycle bypass
    vt.push_back(mk(0,1,3,5,0,16'h55,2,0, 1,2,16'hBEEF,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,  1,2,1,1,3,5,16'hBEEF,16'h55));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  1,2,1,1,3,5,16'hBEEF,16'h55));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,  1,2,0,0,0,0,0,0));
    // Fill, ignored 4th dispatch, release and in-order issue
    vt.push_back(mk(0,1,4,1,0,16'h1,6,0, 0,0,0,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,1,4,2,0,16'h2,6,0, 0,0,0,0,  1,2,0,0,0,0,0,0));
    vt.push_back(mk(0,1,4,3,0,16'h3,6,0, 0,0,0,0,  1,3,0,0,0,0,0,0));
    vt.push_back(mk(0,1,9,9,0,16'h9,6,0, 0,0,0,0,  0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,6,16'h666,1,  0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  0,0,1,1,4,1,16'h666,16'h1));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  0,0,1,2,4,2,16'h666,16'h2));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,  0,0,1,3,4,3,16'h666,16'h3));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,  0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,2,0,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,3,0,0,  1,1,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,  1,1,0,0,0,0,0,0));

    foreach (vt[i]) begin
      set_in(vt[i].rst, vt[i].dv, vt[i].op, vt[i].rd, vt[i].vj, vt[i].vk, vt[i].qj, vt[i].qk,
             vt[i].cv, vt[i].ct, vt[i].cd, vt[i].fr);
      #1;
      check_out($sformatf("vec%0d", i), vt[i].e_dr, vt[i].e_dt, vt[i].e_fv, vt[i].e_ft,
                vt[i].e_op, vt[i].e_rd, vt[i].e_vj, vt[i].e_vk);
      tick();
    end

    // Stalled FU: payload holds on entry 1, then entry 2 follows
    set_in(0, 1, 5, 6, 16'hA1, 16'hA2, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 7, 8, 16'hB1, 16'hB2, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("hold_first", 1, 2, 1, 1, 5, 6, 16'hA1, 16'hA2);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check_out($sformatf("hold%0d", c), 1, 3, 1, 1, 5, 6, 16'hA1, 16'hA2);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check_out("hold_accept", 1, 3, 1, 1, 5, 6, 16'hA1, 16'hA2);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("hold_next", 1, 3, 1, 2, 7, 8, 16'hB1, 16'hB2);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("hold_drained", 1, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset with entries in EXEC, WAIT and READY
    set_in(0, 1, 1, 1, 16'h1, 16'h1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 2, 2, 0, 16'h2, 7, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 1, 3, 3, 16'h3, 16'h3, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("mix_pre", 1, 3, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("mix_full", 0, 0, 1, 3, 3, 3, 16'h3, 16'h3);
    set_in(1, 1, 4, 4, 0, 0, 0, 0, 1, 1, 16'hDEAD, 1);
    #1;
    check_out("rst_hi", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h1111, 0);
    #1;
    check_out("rst_after", 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h7777, 0);
    #1;
    check_out("rst_old_exec", 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("rst_old_wait", 1, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Random traffic against the model, starting from reset
    for (int n = 0; n < 2000; n++) begin
      set_in((n == 0) || ($urandom_range(0, 99) == 0),
             $urandom_range(0, 9) < 6,
             4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
             ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
             $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
             $urandom_range(0, 9) < 6);
      #1;
      model_check($sformatf("rnd%0d", n));
      model_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
